// File: rtl/jp_lift_seq.sv
// jp_lift_seq: start/busy/done sequencer for one lifting pass.
// Each element takes five cycles: the row RAMs and flags ROM are
// addressed, read, latched into the operand registers, jp_process gets
// an update pulse, and its result goes to the result RAM unless
// jp_process flags it invalid.
//
// Handshake: start is a one-cycle request. It is accepted only while the
// FSM is idle. busy is high from the accepting edge until the edge on
// which done rises. done is a one-cycle pulse. we_res is a one-cycle
// write strobe, and addr_res/din_res are nonzero only while it is high.
module jp_lift_seq #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 144,
  parameter int FLG_W  = 80,
  parameter int RES_W  = 10
) (
  input  logic              clk_fast,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] res_base,
  input  logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] flg_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr_lf,
  output logic [ADDR_W-1:0] addr_sa,
  output logic [ADDR_W-1:0] addr_rt,
  input  logic [DATA_W-1:0] dout_lf,
  input  logic [DATA_W-1:0] dout_sa,
  input  logic [DATA_W-1:0] dout_rt,
  output logic [ADDR_W-1:0] addr_flgs,
  input  logic [FLG_W-1:0]  dout_flgs,
  output logic [DATA_W-1:0] left_s_i,
  output logic [DATA_W-1:0] sam_s_i,
  output logic [DATA_W-1:0] right_s_i,
  output logic [FLG_W-1:0]  flgs_s_i,
  output logic              update_s,
  input  logic [RES_W-1:0]  res_out_x,
  input  logic              noupdate_s,
  output logic [ADDR_W-1:0] addr_res,
  output logic [RES_W-1:0]  din_res,
  output logic              we_res,
  output logic [ADDR_W:0]   skip_cnt,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LATCH = 3'd3,
    S_UPD   = 3'd4,
    S_CAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

  state_t state, next_state;

  // Pass parameters captured at start so the caller may change its inputs freely.
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] res_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_nxt;
  logic              last_elem;
  logic [ADDR_W-1:0] rd_addr;

  assign idx_nxt   = idx + IDX_ONE;
  assign last_elem = (idx_nxt == cnt_q);

  // The three row RAMs are always read at the same row.
  assign addr_lf = rd_addr;
  assign addr_sa = rd_addr;
  assign addr_rt = rd_addr;

  // State register.
  always_ff @(posedge clk_fast) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic, update strobe and state visibility.
  always_comb begin
    next_state = state;
    update_s   = 1'b0;
    dbg_state  = state;
    case (state)
      S_IDLE:  if (start) next_state = (count == '0) ? S_DONE : S_FETCH;
      S_FETCH: next_state = S_WAIT;
      S_WAIT:  next_state = S_LATCH;
      S_LATCH: next_state = S_UPD;
      S_UPD: begin
        update_s   = 1'b1;
        next_state = S_CAP;
      end
      S_CAP:   next_state = last_elem ? S_DONE : S_FETCH;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: pass capture, addressing, operand latch, result write, status.
  always_ff @(posedge clk_fast) begin
    if (reset) begin
      src_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      idx       <= '0;
      rd_addr   <= '0;
      addr_flgs <= '0;
      left_s_i  <= '0;
      sam_s_i   <= '0;
      right_s_i <= '0;
      flgs_s_i  <= '0;
      we_res    <= 1'b0;
      addr_res  <= '0;
      din_res   <= '0;
      skip_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      we_res   <= 1'b0;
      addr_res <= '0;
      din_res  <= '0;
      done     <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q    <= src_base;
            res_q    <= res_base;
            cnt_q    <= count;
            idx      <= '0;
            skip_cnt <= '0;
            busy     <= 1'b1;
            // An empty pass leaves the read ports where they were.
            if (count != '0) begin
              rd_addr   <= src_base;
              addr_flgs <= flg_addr;
            end
          end
        end
        S_LATCH: begin
          left_s_i  <= dout_lf;
          sam_s_i   <= dout_sa;
          right_s_i <= dout_rt;
          flgs_s_i  <= dout_flgs;
        end
        S_CAP: begin
          if (!noupdate_s) begin
            we_res   <= 1'b1;
            addr_res <= res_q + idx[ADDR_W-1:0];
            din_res  <= res_out_x;
          end else begin
            skip_cnt <= skip_cnt + IDX_ONE;
          end
          idx <= idx_nxt;
          if (!last_elem) rd_addr <= src_q + idx_nxt[ADDR_W-1:0];
        end
        S_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jp_lift_seq.sv
// Bench for jp_lift_seq: synchronous RAM/ROM models, a stand-in for
// jp_process, directed passes, and scoreboard monitors for the operand
// hand-off and for result writes.
module tb_jp_lift_seq;
  localparam int AW = 10;
  localparam int DW = 144;
  localparam int FW = 80;
  localparam int RW = 10;

  logic          clk_fast = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_base, res_base, flg_addr;
  logic [AW:0]   count;
  logic          busy, done;
  logic [AW-1:0] addr_lf, addr_sa, addr_rt, addr_flgs, addr_res;
  logic [DW-1:0] dout_lf, dout_sa, dout_rt;
  logic [FW-1:0] dout_flgs;
  logic [DW-1:0] left_s_i, sam_s_i, right_s_i;
  logic [FW-1:0] flgs_s_i;
  logic          update_s, noupdate_s, we_res;
  logic [RW-1:0] res_out_x, din_res;
  logic [AW:0]   skip_cnt;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit nu_en = 1'b0;
  int nu_pos = 0;
  int upd_count = 0;
  int upd_base = 0;

  logic [551:0] exp_op_q[$];
  logic [19:0]  exp_wr_q[$];

  logic [DW-1:0] lf_mem [1024];
  logic [DW-1:0] sa_mem [1024];
  logic [DW-1:0] rt_mem [1024];
  logic [FW-1:0] flg_mem[1024];

  jp_lift_seq #(.ADDR_W(AW), .DATA_W(DW), .FLG_W(FW), .RES_W(RW)) dut (
    .clk_fast(clk_fast), .reset(reset), .start(start),
    .src_base(src_base), .res_base(res_base), .count(count), .flg_addr(flg_addr),
    .busy(busy), .done(done),
    .addr_lf(addr_lf), .addr_sa(addr_sa), .addr_rt(addr_rt),
    .dout_lf(dout_lf), .dout_sa(dout_sa), .dout_rt(dout_rt),
    .addr_flgs(addr_flgs), .dout_flgs(dout_flgs),
    .left_s_i(left_s_i), .sam_s_i(sam_s_i), .right_s_i(right_s_i), .flgs_s_i(flgs_s_i),
    .update_s(update_s), .res_out_x(res_out_x), .noupdate_s(noupdate_s),
    .addr_res(addr_res), .din_res(din_res), .we_res(we_res),
    .skip_cnt(skip_cnt), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk_fast = ~clk_fast;

  // Test words: each RAM k and address a gets a distinct pattern.
  function automatic logic [DW-1:0] mk_word(input int a, input int k);
    logic [7:0] lo;
    lo = 8'(a * 5 + k * 29 + 3);
    return {8'(k), 16'(a), 112'h1a0d_160b_482c_5824, lo};
  endfunction

  function automatic logic [FW-1:0] mk_flg(input int f);
    return {16'(f), 64'h0123_4567_89ab_cdef ^ 64'(f)};
  endfunction

  // Stand-in jp_process result: XOR of the low 10 bits of the three operands.
  function automatic logic [RW-1:0] res_fn(input int a);
    logic [DW-1:0] w0, w1, w2;
    w0 = mk_word(a, 0);
    w1 = mk_word(a, 1);
    w2 = mk_word(a, 2);
    return w0[RW-1:0] ^ w1[RW-1:0] ^ w2[RW-1:0];
  endfunction

  // Synchronous-read RAM/ROM models.
  always @(posedge clk_fast) begin
    dout_lf   <= lf_mem[addr_lf];
    dout_sa   <= sa_mem[addr_sa];
    dout_rt   <= rt_mem[addr_rt];
    dout_flgs <= flg_mem[addr_flgs];
  end

  // jp_process stand-in; noupdate_s is forced for one chosen element of a pass.
  assign res_out_x  = left_s_i[RW-1:0] ^ sam_s_i[RW-1:0] ^ right_s_i[RW-1:0];
  assign noupdate_s = nu_en && ((upd_count - upd_base) == nu_pos);

  task automatic chk(input string nm, input logic [559:0] act, input logic [559:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: operands/addresses on each update pulse, and every result write.
  always @(negedge clk_fast) begin
    if (mon_en) begin
      if (update_s) begin
        upd_count++;
        if (exp_op_q.size() == 0) chk("op_unexpected", 1, 0);
        else chk("op_match",
                 {addr_lf, addr_sa, addr_rt, addr_flgs, left_s_i, sam_s_i, right_s_i, flgs_s_i},
                 exp_op_q.pop_front());
      end
      if (we_res) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", {addr_res, din_res}, 0);
        else chk("wr_match", {addr_res, din_res}, exp_wr_q.pop_front());
      end else if ((addr_res != '0) || (din_res != '0)) begin
        chk("wr_idle_zero", {addr_res, din_res}, 0);
      end
    end
  end

  // One complete pass; nu_at > 0 forces noupdate_s on that (1-based) element.
  task automatic run_pass(input int src, input int res, input int cnt, input int flg, input int nu_at);
    int skips, cyc, a;
    bit got;
    skips = 0;
    for (int k = 0; k < cnt; k++) begin
      a = (src + k) % 1024;
      exp_op_q.push_back({10'(a), 10'(a), 10'(a), 10'(flg),
                          mk_word(a, 0), mk_word(a, 1), mk_word(a, 2), mk_flg(flg)});
      if (k + 1 == nu_at) skips++;
      else exp_wr_q.push_back({10'((res + k) % 1024), res_fn(a)});
    end
    nu_en    = (nu_at > 0);
    nu_pos   = nu_at;
    upd_base = upd_count;
    src_base = 10'(src);
    res_base = 10'(res);
    count    = 11'(cnt);
    flg_addr = 10'(flg);
    start    = 1'b1;
    @(posedge clk_fast);
    cyc = 1;
    @(negedge clk_fast);
    start    = 1'b0;
    // Inputs changing mid-pass must not matter.
    src_base = ~src_base;
    res_base = ~res_base;
    count    = 11'h7ff;
    flg_addr = ~flg_addr;
    chk("busy_after_start", busy, 1);
    got = 1'b0;
    while (!got && cyc < 300) begin
      @(posedge clk_fast);
      cyc++;
      @(negedge clk_fast);
      // A start pulse in the middle of a pass must be ignored.
      start = (cnt > 0) && (cyc == 3);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    chk("latency", cyc, 5 * cnt + 2);
    chk("busy_at_done", busy, 0);
    chk("skip_cnt", skip_cnt, skips);
    @(posedge clk_fast);
    @(negedge clk_fast);
    chk("done_one_cycle", done, 0);
    chk("op_q_empty", exp_op_q.size(), 0);
    chk("wr_q_empty", exp_wr_q.size(), 0);
    nu_en = 1'b0;
  endtask

  // Reset during the update cycle of element 3 of a 4-element pass.
  task automatic run_reset_mid();
    int seen, cyc, dn, a;
    for (int k = 0; k < 3; k++) begin
      a = 40 + k;
      exp_op_q.push_back({10'(a), 10'(a), 10'(a), 10'(0),
                          mk_word(a, 0), mk_word(a, 1), mk_word(a, 2), mk_flg(0)});
      if (k < 2) exp_wr_q.push_back({10'(60 + k), res_fn(a)});
    end
    nu_en    = 1'b0;
    src_base = 10'd40;
    res_base = 10'd60;
    count    = 11'd4;
    flg_addr = 10'd0;
    start    = 1'b1;
    @(posedge clk_fast);
    @(negedge clk_fast);
    start = 1'b0;
    seen = 0;
    cyc  = 0;
    while (seen < 3 && cyc < 100) begin
      if (update_s) seen++;
      if (seen < 3) begin
        @(posedge clk_fast);
        @(negedge clk_fast);
        cyc++;
      end
    end
    chk("rst_reached_upd3", seen, 3);
    reset = 1'b1;
    @(posedge clk_fast);
    @(negedge clk_fast);
    reset = 1'b0;
    chk("rst_outs", {busy, done, update_s, we_res, addr_lf, addr_flgs, addr_res, din_res, skip_cnt, dbg_state}, 0);
    chk("rst_ops", {left_s_i, sam_s_i, right_s_i, flgs_s_i}, 0);
    dn = 0;
    repeat (10) begin
      @(posedge clk_fast);
      @(negedge clk_fast);
      if (done || we_res) dn++;
    end
    chk("rst_no_done_no_write", dn, 0);
    chk("rst_op_q_empty", exp_op_q.size(), 0);
    chk("rst_wr_q_empty", exp_wr_q.size(), 0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      lf_mem[a]  = mk_word(a, 0);
      sa_mem[a]  = mk_word(a, 1);
      rt_mem[a]  = mk_word(a, 2);
      flg_mem[a] = mk_flg(a);
    end
    reset    = 1'b1;
    start    = 1'b0;
    src_base = '0;
    res_base = '0;
    count    = '0;
    flg_addr = '0;
    repeat (3) @(posedge clk_fast);
    @(negedge clk_fast);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset then idle.
    repeat (10) begin
      chk("idle_outs", {busy, done, update_s, we_res, addr_lf, addr_flgs, addr_res, din_res, skip_cnt, dbg_state}, 0);
      chk("idle_ops", {left_s_i, sam_s_i, right_s_i, flgs_s_i}, 0);
      @(posedge clk_fast);
      @(negedge clk_fast);
    end

    run_pass(0, 0, 1, 0, 0);          // single element
    run_pass(0, 0, 4, 0, 0);          // predict pass
    run_pass(0, 4, 4, 15, 0);         // update pass
    run_pass(1022, 1023, 3, 0, 0);    // address wrap
    run_pass(8, 20, 4, 15, 2);        // noupdate on element 2
    run_pass(5, 5, 0, 0, 0);          // empty pass
    run_reset_mid();
    run_pass(100, 200, 2, 15, 0);     // normal pass after reset

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
